autoconfig_ram_multi: RTL
=========================

Name: autoconfig_ram_multi

Overview:
Parametrised Zorro II autoconfig controller for 1..NBOARDS chained fast-RAM boards on the A500 expansion bus. It replaces the single-board RAM config logic beside the IDE block. Each board presents its own nibble-wide config ROM at $E80000 in turn, latches its base address and drives its own RAM chip enable. It also raises a DTACK range for mapped RAM and chains _CONFIGOUT once every board is configured or shut up.

Parameters:
NBOARDS, 2, number of chained RAM boards (1..4)
SIZE_CODE, 3'b110, Zorro II size code per board (001=64K .. 111=4M, 000=8M); all boards share it
PRODUCT, 8'h0A, product number
MANUFACTURER, 16'h07DB, manufacturer ID
SERIAL, 32'h0000_0001, serial number; board i reports SERIAL+i

Ports:
CLK  in  1  bus clock (7.09 MHz CPU clock)
RESET  in  1  synchronous reset, active high
_AS  in  1  68000 address strobe
R_W  in  1  1 = read
_UDS  in  1  upper data strobe
AH  in  8  address A23..A16
AL  in  6  address A6..A1
D_IN  in  4  data D15..D12 from bus
_CONFIGIN  in  1  chain input, low = this chain may configure
_CONFIGOUT  out  1  low once all boards are done
D_OUT  out  4  config nibble to D15..D12
D_OE  out  1  drive D_OUT onto the bus
RAM_CE  out  NBOARDS  per-board chip enable, active high
DTACK_RANGE  out  1  address hits any configured board
CFG_PTR  out  3  index of the board currently in config space (NBOARDS = done)

Behaviour:
- One clock, synchronous active-high RESET.
- Reset values: CFG_PTR=0, all boards unconfigured, base=0, D_OE=0, RAM_CE=0, DTACK_RANGE=0, _CONFIGOUT=1, low-nibble latch=0.
- Config window: CFG_PTR<NBOARDS, _CONFIGIN=0, AH=8'hE8, _AS=0.
- Reads in the window: D_OE=1 combinationally while _AS=0 and R_W=1. Offset = {AL,1'b0}.
  - $00 -> 4'hE (Zorro II, add to free list, no ROM).
  - $02 -> {1'b0 (chained when CFG_PTR<NBOARDS-1 is set to 1), SIZE_CODE}.
  - $04/$06 -> ~PRODUCT nibbles.
  - $10..$16 -> ~MANUFACTURER nibbles, MSN first.
  - $18..$26 -> ~serial nibbles.
  - $40/$42 -> 4'h0.
  - All other offsets -> 4'hF.
- Write capture: a write qualifies on the first CLK edge with _AS=0, _UDS=0, R_W=0 in the window. A per-cycle 'taken' flag blocks re-capture until _AS returns high.
  - $4A: latch D_IN into base[19:16].
  - $48: latch D_IN into base[23:20], mark the board configured, CFG_PTR++ on the same edge.
  - $4C: mark the board shut-up (never maps), CFG_PTR++.
- Board FSM per board: UNCFG -> (current and $48) CONFIGURED | (current and $4C) SHUTUP. Only RESET leaves CONFIGURED or SHUTUP.
- _CONFIGOUT=0 registered, one cycle after CFG_PTR reaches NBOARDS; it never returns high except on RESET.
- Match, combinational: configured and (AH & mask) == (base & mask). mask = top bits per the size code; sizes below 64K are not supported. RAM_CE[i] = match & !_AS. DTACK_RANGE = OR of matches & !_AS.
- Overlapping bases: lowest index wins RAM_CE; DTACK_RANGE still asserts.
- _CONFIGIN rising mid-sequence: the window closes and state is retained. Config resumes on the next fall.
- RESET mid-bus-cycle: the state clears and D_OE drops on the same edge.

Optional Feature:
RANGER_FALLBACK_EN.
- Defined: adds input CFG_BYPASS (sampled at RESET) and output OVR_RANGE. With CFG_BYPASS=1 at reset, board 0 is forced CONFIGURED at base $C0 and the remaining boards are forced SHUTUP. CFG_PTR=NBOARDS and _CONFIGOUT=0 after reset. OVR_RANGE = board-0 match & !_AS, to override the A500 slow RAM decoder.
- Undefined: the port is absent, board 0 autoconfigures normally and no OVR is ever requested.

Decomposition:
- Package ide_ram_pkg:
  - size-code localparams
  - config offset constants ($00,$02,$04,$06,$10,$18,$40,$48,$4A,$4C)
  - board state enum {UNCFG, CONFIGURED, SHUTUP}
  - function size_mask(size_code) returning 8-bit address mask
- Sub-module autoconfig_board: one per board via generate. It holds the FSM, the base register, the nibble ROM mux and the match logic. The top holds CFG_PTR, write qualification, the chain and the priority OR.

Test Plan:
- RESET, read $E80000..$E80026 with NBOARDS=2 -> $00=E, $02=8|6 (chained, 2M), $04=F, $06=5, serial nibbles inverted. _CONFIGOUT=1.
- Write $4A=0, $48=2 -> board0 base $20. CFG_PTR=1. Read $E80002 -> 4'h6 (last, unchained). Access $200000..$3FFFFF -> RAM_CE[0]=1. $400000 -> no match.
- Board1 $4C shut-up -> CFG_PTR=2 and _CONFIGOUT=0 the next cycle. Board1 never asserts RAM_CE. The window returns D_OE=0.
- Write held for 4 cycles of _AS low -> exactly one capture. CFG_PTR increments by 1, not 4.
- _CONFIGIN=1 during a read of $E80000 -> D_OE=0. Drop it again -> config continues at the same CFG_PTR.
- RANGER_FALLBACK_EN with CFG_BYPASS=1 at reset -> an access at $C00000 asserts RAM_CE[0], OVR_RANGE and DTACK_RANGE. _CONFIGOUT=0 immediately.

Source files
------------

// File: rtl/ide_ram_pkg.sv
// Shared constants, board state type and size-mask helper for the chained
// Zorro II fast-RAM autoconfig controller.
package ide_ram_pkg;

    localparam logic [2:0] SZ_8M   = 3'b000;
    localparam logic [2:0] SZ_64K  = 3'b001;
    localparam logic [2:0] SZ_128K = 3'b010;
    localparam logic [2:0] SZ_256K = 3'b011;
    localparam logic [2:0] SZ_512K = 3'b100;
    localparam logic [2:0] SZ_1M   = 3'b101;
    localparam logic [2:0] SZ_2M   = 3'b110;
    localparam logic [2:0] SZ_4M   = 3'b111;

    // Byte offsets inside the $E80000 config page
    localparam logic [6:0] OFS_TYPE       = 7'h00;
    localparam logic [6:0] OFS_SIZE       = 7'h02;
    localparam logic [6:0] OFS_PROD_HI    = 7'h04;
    localparam logic [6:0] OFS_PROD_LO    = 7'h06;
    localparam logic [6:0] OFS_MFR        = 7'h10;
    localparam logic [6:0] OFS_SERIAL     = 7'h18;
    localparam logic [6:0] OFS_SERIAL_END = 7'h26;
    localparam logic [6:0] OFS_CTRL       = 7'h40;
    localparam logic [6:0] OFS_CTRL_HI    = 7'h42;
    localparam logic [6:0] OFS_BASE_HI    = 7'h48;
    localparam logic [6:0] OFS_BASE_LO    = 7'h4A;
    localparam logic [6:0] OFS_SHUTUP     = 7'h4C;

    localparam logic [7:0] CONFIG_BANK = 8'hE8;
    localparam logic [7:0] BYPASS_BASE = 8'hC0;

    typedef enum logic [1:0] {
        UNCFG      = 2'd0,
        CONFIGURED = 2'd1,
        SHUTUP     = 2'd2
    } board_state_t;

    // Address bits A23..A16 that must equal the base for a board of this size
    function automatic logic [7:0] size_mask(input logic [2:0] size_code);
        logic [7:0] mask;
        case (size_code)
            SZ_64K:  mask = 8'hFF;
            SZ_128K: mask = 8'hFE;
            SZ_256K: mask = 8'hFC;
            SZ_512K: mask = 8'hF8;
            SZ_1M:   mask = 8'hF0;
            SZ_2M:   mask = 8'hE0;
            SZ_4M:   mask = 8'hC0;
            default: mask = 8'h80;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/autoconfig_board.sv
// One chained RAM board: config state machine, base register, config ROM
// nibble mux and address match.
module autoconfig_board
    import ide_ram_pkg::*;
#(
    parameter int unsigned IDX          = 0,
    parameter int unsigned NBOARDS      = 2,
    parameter logic [2:0]  SIZE_CODE    = SZ_2M,
    parameter logic [7:0]  PRODUCT      = 8'h0A,
    parameter logic [15:0] MANUFACTURER = 16'h07DB,
    parameter logic [31:0] SERIAL       = 32'h0000_0001
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       force_cfg,
    input  logic       force_shut,
    input  logic       wr_en,
    input  logic [6:0] offset,
    input  logic [3:0] d_in,
    input  logic [7:0] ah,
    output logic [3:0] rom_nibble,
    output logic       match
);

    localparam logic        CHAINED    = (IDX + 1 < NBOARDS);
    localparam logic [7:0]  MASK       = size_mask(SIZE_CODE);
    localparam logic [7:0]  PROD_INV   = ~PRODUCT;
    localparam logic [15:0] MFR_INV    = ~MANUFACTURER;
    localparam logic [31:0] SERIAL_INV = ~(SERIAL + 32'(IDX));

    board_state_t state_reg, state_next;
    logic [7:0]   base_reg, base_next;
    logic [2:0]   serial_idx;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= force_cfg ? CONFIGURED : (force_shut ? SHUTUP : UNCFG);
            base_reg  <= force_cfg ? BYPASS_BASE : 8'h00;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        if (state_reg == UNCFG && wr_en) begin
            case (offset)
                OFS_BASE_LO: base_next[3:0] = d_in;
                OFS_BASE_HI: begin
                    base_next[7:4] = d_in;
                    state_next     = CONFIGURED;
                end
                OFS_SHUTUP:  state_next = SHUTUP;
                default:     ;
            endcase
        end
    end

    assign serial_idx = 3'((offset - OFS_SERIAL) >> 1);

    // Nibbles are stored most-significant first, so the index is inverted
    always_comb begin
        rom_nibble = 4'hF;
        if (offset == OFS_TYPE)
            rom_nibble = 4'hE;
        else if (offset == OFS_SIZE)
            rom_nibble = {CHAINED, SIZE_CODE};
        else if (offset == OFS_PROD_HI)
            rom_nibble = PROD_INV[7:4];
        else if (offset == OFS_PROD_LO)
            rom_nibble = PROD_INV[3:0];
        else if (offset >= OFS_MFR && offset < OFS_SERIAL)
            rom_nibble = MFR_INV[{~offset[2:1], 2'b00} +: 4];
        else if (offset >= OFS_SERIAL && offset <= OFS_SERIAL_END)
            rom_nibble = SERIAL_INV[{~serial_idx, 2'b00} +: 4];
        else if (offset == OFS_CTRL || offset == OFS_CTRL_HI)
            rom_nibble = 4'h0;
    end

    assign match = (state_reg == CONFIGURED) && ((ah & MASK) == (base_reg & MASK));

endmodule

// File: rtl/autoconfig_ram_multi.sv
// Zorro II autoconfig controller for NBOARDS chained fast-RAM boards.
// Optional RANGER_FALLBACK_EN adds CFG_BYPASS/OVR_RANGE for a fixed $C0 mapping.
module autoconfig_ram_multi
    import ide_ram_pkg::*;
#(
    parameter int unsigned NBOARDS      = 2,
    parameter logic [2:0]  SIZE_CODE    = 3'b110,
    parameter logic [7:0]  PRODUCT      = 8'h0A,
    parameter logic [15:0] MANUFACTURER = 16'h07DB,
    parameter logic [31:0] SERIAL       = 32'h0000_0001
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               _AS,
    input  logic               R_W,
    input  logic               _UDS,
    input  logic [7:0]         AH,
    input  logic [5:0]         AL,
    input  logic [3:0]         D_IN,
    input  logic               _CONFIGIN,
`ifdef RANGER_FALLBACK_EN
    input  logic               CFG_BYPASS,
    output logic               OVR_RANGE,
`endif
    output logic               _CONFIGOUT,
    output logic [3:0]         D_OUT,
    output logic               D_OE,
    output logic [NBOARDS-1:0] RAM_CE,
    output logic               DTACK_RANGE,
    output logic [2:0]         CFG_PTR
);

    localparam logic [2:0] NB = 3'(NBOARDS);

    logic [2:0]   cfg_ptr_reg, cfg_ptr_next;
    logic         configout_reg;
    logic         taken_reg;
    logic         bypass;
    logic [6:0]   offset;
    logic         window;
    logic         wr_strobe;
    logic         advance;
    logic [3:0]   rom_nibble [NBOARDS];
    logic [NBOARDS-1:0] match;
    logic [3:0]   rom_sel;
    logic         ce_hit;

`ifdef RANGER_FALLBACK_EN
    assign bypass    = CFG_BYPASS;
    assign OVR_RANGE = match[0] && !_AS;
`else
    assign bypass = 1'b0;
`endif

    assign offset    = {AL, 1'b0};
    assign window    = (cfg_ptr_reg < NB) && !_CONFIGIN && (AH == CONFIG_BANK) && !_AS;
    assign wr_strobe = window && !_UDS && !R_W && !taken_reg;
    assign advance   = wr_strobe && (offset == OFS_BASE_HI || offset == OFS_SHUTUP);
    assign cfg_ptr_next = advance ? cfg_ptr_reg + 3'd1 : cfg_ptr_reg;

    // An interrupted write cycle must not be captured once reset releases
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cfg_ptr_reg   <= bypass ? NB : 3'd0;
            configout_reg <= !bypass;
            taken_reg     <= !_AS;
        end else begin
            cfg_ptr_reg <= cfg_ptr_next;
            if (cfg_ptr_reg == NB)
                configout_reg <= 1'b0;
            taken_reg <= _AS ? 1'b0 : (taken_reg || wr_strobe);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBOARDS; gi++) begin : g_board
            autoconfig_board #(
                .IDX          (gi),
                .NBOARDS      (NBOARDS),
                .SIZE_CODE    (SIZE_CODE),
                .PRODUCT      (PRODUCT),
                .MANUFACTURER (MANUFACTURER),
                .SERIAL       (SERIAL)
            ) u_board (
                .clk        (CLK),
                .srst       (RESET),
                .force_cfg  (bypass && (gi == 0)),
                .force_shut (bypass && (gi != 0)),
                .wr_en      (wr_strobe && (cfg_ptr_reg == 3'(gi))),
                .offset     (offset),
                .d_in       (D_IN),
                .ah         (AH),
                .rom_nibble (rom_nibble[gi]),
                .match      (match[gi])
            );
        end
    endgenerate

    always_comb begin
        rom_sel = 4'hF;
        for (int i = 0; i < NBOARDS; i++) begin
            if (cfg_ptr_reg == 3'(i))
                rom_sel = rom_nibble[i];
        end
    end

    // Lowest-index board wins when bases overlap
    always_comb begin
        ce_hit = 1'b0;
        RAM_CE = '0;
        for (int i = 0; i < NBOARDS; i++) begin
            RAM_CE[i] = match[i] && !ce_hit && !_AS;
            ce_hit    = ce_hit || match[i];
        end
    end

    assign D_OE        = window && R_W && !RESET;
    assign D_OUT       = D_OE ? rom_sel : 4'h0;
    assign DTACK_RANGE = (|match) && !_AS;
    assign _CONFIGOUT  = configout_reg;
    assign CFG_PTR     = cfg_ptr_reg;

endmodule
